// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, digit-enable constants and digit index type for seg7_scan3
package seg7_pkg;
    typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2} digit_e;
    // index i holds the gfedcba pattern for decimal digit i
    localparam logic [9:0][6:0] DIGIT_PAT = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                             7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [2:0] AN_D0  = 3'b110;
    localparam logic [2:0] AN_D1  = 3'b101;
    localparam logic [2:0] AN_D2  = 3'b011;
    localparam logic [2:0] AN_OFF = 3'b111;
    function automatic logic [2:0] an_of(digit_e d);
        return d == D0 ? AN_D0 : d == D1 ? AN_D1 : AN_D2;
    endfunction
endpackage

// File: rtl/seg7_scan3_if.sv
// seg7_scan3_if: BCD digit inputs and multiplexed display outputs of seg7_scan3
interface seg7_scan3_if;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame;
    modport master (output bcd0, bcd1, bcd2, input seg, an, frame);
    modport slave (input bcd0, bcd1, bcd2, output seg, an, frame);
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to gfedcba decoder; non-decimal codes show a dash
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb seg = bcd > 4'd9 ? SEG_DASH : DIGIT_PAT[bcd];
endmodule

// File: rtl/seg7_scan3.sv
// seg7_scan3: 3-digit multiplexed 7-segment scanner with frame-aligned input snapshots.
// Optional macro SEG7_LZB_EN enables leading-zero blanking of digits 2 and 1.
module seg7_scan3
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic          ck,
    input  logic          rs,
    seg7_scan3_if.slave   bus
);
    logic [15:0] div_cnt;
    digit_e      idx;
    logic [3:0]  snap0, snap1, snap2;
    logic [3:0]  cur;
    logic [6:0]  dec;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame;
    logic        tick;
    logic        blank;

    assign tick = div_cnt == 16'(SCAN_DIV - 1);
    assign cur  = idx == D0 ? snap0 : idx == D1 ? snap1 : snap2;

    bcd_to_seg7 u_dec (.bcd(cur), .seg(dec));

`ifdef SEG7_LZB_EN
    // values 10..15 count as nonzero, so only a literal 0 blanks
    assign blank = (idx == D2 && snap2 == 4'd0) || (idx == D1 && snap2 == 4'd0 && snap1 == 4'd0);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge ck or negedge rs)
        if (!rs) begin
            div_cnt <= '0;
            idx     <= D0;
            snap0   <= '0;
            snap1   <= '0;
            snap2   <= '0;
            seg     <= SEG_BLANK;
            an      <= AN_OFF;
            frame   <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 16'd1;
            if (tick)
                idx <= idx == D2 ? D0 : idx == D0 ? D1 : D2;
            // inputs are sampled only at the frame boundary to avoid tearing
            if (tick && idx == D2) begin
                snap0 <= bus.bcd0;
                snap1 <= bus.bcd1;
                snap2 <= bus.bcd2;
            end
            frame <= tick && idx == D2;
            seg   <= blank ? SEG_BLANK : dec;
            an    <= an_of(idx);
        end

    assign bus.seg   = seg;
    assign bus.an    = an;
    assign bus.frame = frame;
endmodule

// File: tb/tb_seg7_scan3.sv
// tb_seg7_scan3: randomized self-checking bench for seg7_scan3 against a cycle-count reference model
module tb_seg7_scan3;
    localparam int SD = 4;
    localparam int PER = 3 * SD;

    logic ck = 1'b0;
    logic rs = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   k = 0;
    int   ref_snap [3] = '{0, 0, 0};
    logic [6:0] exp_seg;
    logic [2:0] exp_an;
    logic       exp_frame;
    logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg7_scan3_if bus ();
    seg7_scan3 #(.SCAN_DIV(SD)) dut (.ck(ck), .rs(rs), .bus(bus));

    always #5 ck = ~ck;

    function automatic logic [6:0] expect_seg(int d);
`ifdef SEG7_LZB_EN
        if ((d == 2 && ref_snap[2] == 0) || (d == 1 && ref_snap[2] == 0 && ref_snap[1] == 0))
            return 7'h00;
`endif
        return ref_snap[d] > 9 ? 7'h40 : pat_tab[ref_snap[d]];
    endfunction

    // k counts rising edges since reset release; edge k shows the digit active before it
    task automatic cycle();
        int d;
        @(posedge ck);
        #1;
        k++;
        d = ((k - 1) / SD) % 3;
        exp_an    = ~(3'b001 << d);
        exp_frame = (k % PER) == 0;
        exp_seg   = expect_seg(d);
        if (exp_frame)
            ref_snap = '{int'(bus.bcd0), int'(bus.bcd1), int'(bus.bcd2)};
    endtask

    task automatic set_bcd(int b0, int b1, int b2);
        bus.bcd0 = 4'(b0);
        bus.bcd1 = 4'(b1);
        bus.bcd2 = 4'(b2);
    endtask

    task automatic release_reset();
        @(negedge ck);
        rs = 1'b1;
        k = 0;
        ref_snap = '{0, 0, 0};
    endtask

    task automatic test_reset();
        set_bcd(3, 2, 1);
        repeat (2) @(posedge ck);
        #1;
        compared += 3;
        if (bus.seg !== 7'h00) begin mismatched++; $display("FAIL reset_seg got %h want 00", bus.seg); end
        if (bus.an !== 3'b111) begin mismatched++; $display("FAIL reset_an got %b want 111", bus.an); end
        if (bus.frame !== 1'b0) begin mismatched++; $display("FAIL reset_frame got %b want 0", bus.frame); end
        release_reset();
        cycle();
        compared += 2;
        if (bus.seg !== 7'h3F) begin mismatched++; $display("FAIL first_seg got %h want 3F", bus.seg); end
        if (bus.an !== 3'b110) begin mismatched++; $display("FAIL first_an got %b want 110", bus.an); end
    endtask

    task automatic test_patterns();
        int tab [6][3] = '{'{3, 2, 1}, '{4, 0, 12}, '{5, 0, 0}, '{0, 0, 0}, '{9, 15, 0}, '{0, 10, 8}};
        for (int p = 0; p < 6; p++) begin
            set_bcd(tab[p][0], tab[p][1], tab[p][2]);
            for (int c = 0; c < 3 * PER; c++) begin
                cycle();
                compared += 3;
                if (bus.seg !== exp_seg) begin mismatched++; $display("FAIL pattern%0d_seg k=%0d got %h want %h", p, k, bus.seg, exp_seg); end
                if (bus.an !== exp_an) begin mismatched++; $display("FAIL pattern%0d_an k=%0d got %b want %b", p, k, bus.an, exp_an); end
                if (bus.frame !== exp_frame) begin mismatched++; $display("FAIL pattern%0d_frame k=%0d got %b want %b", p, k, bus.frame, exp_frame); end
            end
        end
    endtask

    task automatic test_midframe();
        set_bcd(3, 2, 1);
        do cycle(); while (k % PER != 5);
        bus.bcd0 = 4'd7;
        for (int c = 0; c < 3 * PER; c++) begin
            cycle();
            compared += 2;
            if (bus.seg !== exp_seg) begin mismatched++; $display("FAIL midframe_seg k=%0d got %h want %h", k, bus.seg, exp_seg); end
            if (bus.frame !== exp_frame) begin mismatched++; $display("FAIL midframe_frame k=%0d got %b want %b", k, bus.frame, exp_frame); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 20 * PER; c++) begin
            if ($urandom_range(0, 6) == 0)
                set_bcd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            cycle();
            compared += 3;
            if (bus.seg !== exp_seg) begin mismatched++; $display("FAIL random_seg k=%0d got %h want %h", k, bus.seg, exp_seg); end
            if (bus.an !== exp_an) begin mismatched++; $display("FAIL random_an k=%0d got %b want %b", k, bus.an, exp_an); end
            if (bus.frame !== exp_frame) begin mismatched++; $display("FAIL random_frame k=%0d got %b want %b", k, bus.frame, exp_frame); end
        end
    endtask

    task automatic test_reset_mid();
        set_bcd(8, 8, 8);
        do cycle(); while (k % PER != 5);
        #2;
        rs = 1'b0;
        #1;
        compared += 3;
        if (bus.seg !== 7'h00) begin mismatched++; $display("FAIL midreset_seg got %h want 00", bus.seg); end
        if (bus.an !== 3'b111) begin mismatched++; $display("FAIL midreset_an got %b want 111", bus.an); end
        if (bus.frame !== 1'b0) begin mismatched++; $display("FAIL midreset_frame got %b want 0", bus.frame); end
        repeat (3) @(posedge ck);
        release_reset();
        for (int c = 0; c < 2 * PER; c++) begin
            cycle();
            compared += 3;
            if (bus.seg !== exp_seg) begin mismatched++; $display("FAIL postreset_seg k=%0d got %h want %h", k, bus.seg, exp_seg); end
            if (bus.an !== exp_an) begin mismatched++; $display("FAIL postreset_an k=%0d got %b want %b", k, bus.an, exp_an); end
            if (bus.frame !== exp_frame) begin mismatched++; $display("FAIL postreset_frame k=%0d got %b want %b", k, bus.frame, exp_frame); end
        end
    endtask

    task automatic test_counter();
        int cnt = int'($urandom_range(0, 999));
        int last_frame = k;
        for (int c = 0; c < 2000; c++) begin
            set_bcd(cnt % 10, (cnt / 10) % 10, cnt / 100);
            cycle();
            cnt = (cnt + 1) % 1000;
            compared += 3;
            if (bus.seg !== exp_seg) begin mismatched++; $display("FAIL counter_seg k=%0d got %h want %h", k, bus.seg, exp_seg); end
            if ($countones(~bus.an) != 1) begin mismatched++; $display("FAIL counter_onehot k=%0d got %b want one low bit", k, bus.an); end
            if (bus.frame === 1'b1) begin
                compared++;
                if (k - last_frame != PER && last_frame != 0) begin mismatched++; $display("FAIL counter_period k=%0d got %0d want %0d", k, k - last_frame, PER); end
                last_frame = k;
            end else if (exp_frame) begin
                mismatched++;
                $display("FAIL counter_frame k=%0d got 0 want 1", k);
            end
        end
    endtask

    initial begin
        set_bcd(0, 0, 0);
        test_reset();
        test_patterns();
        test_midframe();
        test_random();
        test_reset_mid();
        test_counter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
